// File: rtl/calc_pkg.sv
// calc_pkg: key codes, opcode encoding and entry FSM states shared by the key-entry block.
package calc_pkg;
  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_CLR = 4'hE;
  localparam logic [3:0] KEY_EQ  = 4'hF;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;
  typedef enum logic [2:0] {S_A, S_OP, S_B, S_REQ, S_DONE} state_t;
  function automatic logic [1:0] key2op(input logic [3:0] k);
    return 2'(k - KEY_ADD);
  endfunction
endpackage

// File: rtl/bcd_entry_reg.sv
// bcd_entry_reg: BCD operand shift register with digit counter, leading-zero suppression and full flag.
module bcd_entry_reg #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_zero_i,
  input  logic                shift_i,
  input  logic [3:0]          digit_i,
  output logic [4*DIGITS-1:0] value_o,
  output logic                full_o
);
  localparam int CW = $clog2(DIGITS + 1);
  logic [4*DIGITS-1:0] val_q, val_d, base_v;
  logic [CW-1:0] cnt_q, cnt_d, base_c;
  logic take;
  // load-zero applies before the shift so a fresh entry can start in the same cycle
  always_comb begin
    base_v = load_zero_i ? '0 : val_q;
    base_c = load_zero_i ? '0 : cnt_q;
    take   = shift_i && !(base_c == '0 && digit_i == 4'd0) && base_c != CW'(DIGITS);
    val_d  = take ? {base_v[4*DIGITS-5:0], digit_i} : base_v;
    cnt_d  = take ? base_c + 1'b1 : base_c;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      val_q <= '0;
      cnt_q <= '0;
    end else begin
      val_q <= val_d;
      cnt_q <= cnt_d;
    end
  assign value_o = val_q;
  assign full_o  = cnt_q == CW'(DIGITS);
endmodule

// File: rtl/calc_key_entry.sv
// calc_key_entry: assembles A op B from key events and requests computation via req/ack.
module calc_key_entry
  import calc_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_detect,
  input  logic [3:0]          key_code,
  input  logic                calc_ack,
  output logic [4*DIGITS-1:0] op_a,
  output logic [4*DIGITS-1:0] op_b,
  output logic [1:0]          opcode,
  output logic                calc_req,
  output logic [4*DIGITS-1:0] display,
  output logic                ovf,
  output logic                busy
);
  state_t state_q;
  logic [1:0] opcode_q;
  logic req_q, ovf_q;
  logic is_dig, is_op, is_clr, is_eq, clr_all;
  logic a_clr, a_shift, a_full, b_clr, b_shift, b_full, ovf_set;
  always_comb begin
    is_dig  = key_detect && key_code <= 4'd9;
    is_op   = key_detect && key_code >= KEY_ADD && key_code <= KEY_DIV;
    is_clr  = key_detect && key_code == KEY_CLR;
    is_eq   = key_detect && key_code == KEY_EQ;
    clr_all = is_clr && state_q != S_REQ;
    a_clr   = clr_all || (state_q == S_DONE && is_dig);
    a_shift = is_dig && (state_q == S_A || state_q == S_DONE);
    b_clr   = clr_all || (is_dig && state_q == S_OP) || (state_q == S_DONE && (is_dig || is_op));
    b_shift = is_dig && (state_q == S_OP || state_q == S_B);
    ovf_set = (a_shift && a_full && !a_clr) || (b_shift && b_full && !b_clr);
  end
  bcd_entry_reg #(.DIGITS(DIGITS)) u_a (
    .clk(clk), .rst(rst), .load_zero_i(a_clr), .shift_i(a_shift),
    .digit_i(key_code), .value_o(op_a), .full_o(a_full)
  );
  bcd_entry_reg #(.DIGITS(DIGITS)) u_b (
    .clk(clk), .rst(rst), .load_zero_i(b_clr), .shift_i(b_shift),
    .digit_i(key_code), .value_o(op_b), .full_o(b_full)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q  <= S_A;
      opcode_q <= OP_ADD;
      req_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (clr_all) begin
      state_q  <= S_A;
      opcode_q <= OP_ADD;
      req_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (ovf_set) ovf_q <= 1'b1;
      case (state_q)
        S_A: if (is_op) begin
          opcode_q <= key2op(key_code);
          state_q  <= S_OP;
        end
        S_OP: if (is_op) opcode_q <= key2op(key_code);
              else if (is_dig) state_q <= S_B;
        S_B: if (is_eq) begin
          state_q <= S_REQ;
          req_q   <= 1'b1;
        end
        S_REQ: if (calc_ack) begin
          state_q <= S_DONE;
          req_q   <= 1'b0;
        end
        S_DONE: if (is_dig) begin
          ovf_q   <= 1'b0;
          state_q <= S_A;
        end else if (is_op) begin
          opcode_q <= key2op(key_code);
          state_q  <= S_OP;
        end
        default: state_q <= S_A;
      endcase
    end
  assign opcode   = opcode_q;
  assign calc_req = req_q;
  assign ovf      = ovf_q;
  assign busy     = state_q == S_REQ;
  assign display  = (state_q == S_A || state_q == S_OP) ? op_a : state_q == S_B ? op_b : '0;
endmodule
